// File: rtl/nms_pkg.sv
// Shared definitions for the NMS window scheduler: state encoding, ring geometry, helpers.
package nms_pkg;

    localparam int PIX_W  = 10;
    localparam int SLOT_W = 2;
    localparam int NSLOT  = 4;
    localparam int ROW_W  = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_BURST = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Ring slot that holds a given frame row (rows are written round-robin).
    function automatic logic [SLOT_W-1:0] slot_of(input logic [ROW_W-1:0] row);
        return SLOT_W'(row);
    endfunction

endpackage

// File: rtl/nms_line_ram.sv
// One row of the line-buffer ring: single write port, single synchronous read port.
module nms_line_ram
    import nms_pkg::*;
#(
    parameter int DEPTH = 250,
    parameter int WIDTH = PIX_W,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Pixel storage; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Registered read; holds its value when not reading so the window outputs stay stable between bursts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       o_rdata <= '0;
        else if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/nms_window_scheduler.sv
// Feeds 3-row windows (r-1, r, r+1) to the suppression stage from a 4-slot line-buffer ring.
// Each centre row goes out as one gap-free PIC_WIDTH burst, with at least ROW_GAP idle cycles between bursts.
//
// state | meaning
// IDLE  | waiting for frame_start
// FILL  | accepting the first three rows of the frame
// BURST | streaming one window row, one column per cycle
// GAP   | enforcing the idle gap and waiting for the next row to complete
// DONE  | one-cycle frame_done pulse
module nms_window_scheduler
    import nms_pkg::*;
#(
    parameter int PIC_WIDTH  = 250,
    parameter int PIC_HEIGHT = 250,
    parameter int WIDTH      = PIX_W,
    parameter int ROW_GAP    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             nms_valid,
    output logic [WIDTH-1:0] nms_din1,
    output logic [WIDTH-1:0] nms_din2,
    output logic [WIDTH-1:0] nms_din3,
    output logic [ROW_W-1:0] row_idx,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;
    localparam int GW = $clog2(ROW_GAP + 1);

    state_t            r_state, w_next;
    logic [CW-1:0]     r_wr_col, r_rd_col;
    logic [SLOT_W-1:0] r_wr_slot, r_sel, w_sel2, w_sel3;
    logic [ROW_W-1:0]  r_rows, r_centre, r_row_idx;
    logic [GW-1:0]     r_gap;
    logic              w_wr_en, w_rd_en, w_rows_ready, w_last_beat, w_room;
    logic [WIDTH-1:0]  w_rdata [NSLOT];

    // r_rows counts completed rows; r_centre is the centre of the current (or next) burst.
    // Rows centre-1 .. centre+2 may be resident, so the writer may run one row ahead of the reader.
    assign w_rows_ready = r_rows >= r_centre + ROW_W'(2);
    assign w_room       = (r_rows < ROW_W'(PIC_HEIGHT)) && (r_rows < r_centre + ROW_W'(3));
    // The read counter wraps to 0 on the read of the last column, which lands on the final beat.
    assign w_last_beat  = (r_state == ST_BURST) && (r_rd_col == '0);
    assign w_wr_en      = s_valid && s_ready;
    // Reads are issued one cycle ahead of each beat so data and nms_valid line up.
    assign w_rd_en      = (w_next == ST_BURST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; frame_start overrides everything and re-arms the frame.
    always_comb begin
        w_next = r_state;
        if (frame_start) begin
            w_next = ST_FILL;
        end else begin
            case (r_state)
                ST_IDLE:  w_next = ST_IDLE;
                ST_FILL:  if (w_rows_ready) w_next = ST_BURST;
                ST_BURST: if (w_last_beat)
                              w_next = (r_centre == ROW_W'(PIC_HEIGHT - 2)) ? ST_DONE : ST_GAP;
                ST_GAP:   if (r_gap == '0 && w_rows_ready) w_next = ST_BURST;
                ST_DONE:  w_next = ST_IDLE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from state; a pixel offered during frame_start is refused since the ring is being cleared.
    always_comb begin
        s_ready    = 1'b0;
        nms_valid  = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b0;
        case (r_state)
            ST_FILL, ST_GAP: begin
                busy    = 1'b1;
                s_ready = w_room && !frame_start;
            end
            ST_BURST: begin
                busy      = 1'b1;
                nms_valid = 1'b1;
                s_ready   = w_room && !frame_start;
            end
            ST_DONE:  frame_done = 1'b1;
            default:  ;
        endcase
    end

    // Write/read pointers, row bookkeeping and the inter-burst gap timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_col  <= '0;
            r_wr_slot <= '0;
            r_rows    <= '0;
            r_rd_col  <= '0;
            r_centre  <= ROW_W'(1);
            r_row_idx <= '0;
            r_sel     <= '0;
            r_gap     <= '0;
        end else if (frame_start) begin
            r_wr_col  <= '0;
            r_wr_slot <= '0;
            r_rows    <= '0;
            r_rd_col  <= '0;
            r_centre  <= ROW_W'(1);
            r_row_idx <= '0;
            r_gap     <= '0;
        end else begin
            if (w_wr_en) begin
                if (r_wr_col == CW'(PIC_WIDTH - 1)) begin
                    r_wr_col  <= '0;
                    r_wr_slot <= r_wr_slot + SLOT_W'(1);
                    r_rows    <= r_rows + ROW_W'(1);
                end else begin
                    r_wr_col  <= r_wr_col + CW'(1);
                end
            end
            if (w_rd_en) begin
                r_rd_col <= (r_rd_col == CW'(PIC_WIDTH - 1)) ? '0 : r_rd_col + CW'(1);
                r_sel    <= slot_of(r_centre - ROW_W'(1));
                if (r_state != ST_BURST) r_row_idx <= r_centre;
            end
            // Advancing the centre releases the slot of row centre-1 from the next cycle on.
            if (w_last_beat) begin
                r_centre <= r_centre + ROW_W'(1);
                r_gap    <= GW'(ROW_GAP - 1);
            end else if (r_state == ST_GAP && r_gap != '0) begin
                r_gap    <= r_gap - GW'(1);
            end
        end
    end

    assign w_sel2   = r_sel + SLOT_W'(1);
    assign w_sel3   = r_sel + SLOT_W'(2);
    assign nms_din1 = w_rdata[r_sel];
    assign nms_din2 = w_rdata[w_sel2];
    assign nms_din3 = w_rdata[w_sel3];
    assign row_idx  = r_row_idx;

    for (genvar g = 0; g < NSLOT; g++) begin : g_ring
        nms_line_ram #(
            .DEPTH (PIC_WIDTH),
            .WIDTH (WIDTH),
            .AW    (CW)
        ) u_ram (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_wr_en && (r_wr_slot == SLOT_W'(g))),
            .i_waddr (r_wr_col),
            .i_wdata (s_data),
            .i_re    (w_rd_en),
            .i_raddr (r_rd_col),
            .o_rdata (w_rdata[g])
        );
    end

endmodule

// File: tb/tb_nms_window_scheduler.sv
// Self-checking bench for nms_window_scheduler (8x5 frame, ROW_GAP 2).
module tb_nms_window_scheduler;

    localparam int W   = 8;
    localparam int H   = 5;
    localparam int PW  = 10;
    localparam int GAP = 2;
    localparam int BUDGET = 1500;

    logic          clk = 1'b0;
    logic          rst, frame_start, s_valid;
    logic [PW-1:0] s_data;
    logic          s_ready, nms_valid, frame_done, busy;
    logic [PW-1:0] nms_din1, nms_din2, nms_din3;
    logic [10:0]   row_idx;

    nms_window_scheduler #(
        .PIC_WIDTH (W), .PIC_HEIGHT (H), .WIDTH (PW), .ROW_GAP (GAP)
    ) dut (
        .clk (clk), .rst (rst), .frame_start (frame_start),
        .s_valid (s_valid), .s_data (s_data), .s_ready (s_ready),
        .nms_valid (nms_valid), .nms_din1 (nms_din1), .nms_din2 (nms_din2),
        .nms_din3 (nms_din3), .row_idx (row_idx), .frame_done (frame_done), .busy (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [PW-1:0] img [H][W];

    typedef struct {
        logic [PW-1:0] d1, d2, d3;
        logic [10:0]   ri;
        int            c;
    } beat_t;

    // Everything below is owned by the monitor; the stimulus side only reads it.
    beat_t beats[$];
    int    fd_cyc[$];
    int    fs_cyc = 0;
    int    fd_busy_bad = 0;
    int    acc_cnt = 0;
    int    t3 = -1;
    bit    rdy_hist [256];
    bit    vld_hist [256];
    int    hold_bad = 0;
    int    coll_cnt = 0;
    bit    prev_ok = 0;
    logic [PW-1:0] p1, p2, p3;

    always @(negedge clk) begin
        int rel;
        logic [1:0] b;
        logic hit;
        if (frame_start) begin
            fs_cyc = cyc;
            beats.delete();
            fd_cyc.delete();
            fd_busy_bad = 0;
            acc_cnt = 0;
            t3 = -1;
            for (int i = 0; i < 256; i++) begin
                rdy_hist[i] = 1'b0;
                vld_hist[i] = 1'b0;
            end
        end
        rel = cyc - fs_cyc;
        if (rst) begin
            prev_ok = 1'b0;
        end else begin
            if (!nms_valid && prev_ok && (nms_din1 !== p1 || nms_din2 !== p2 || nms_din3 !== p3))
                hold_bad++;
            p1 = nms_din1; p2 = nms_din2; p3 = nms_din3;
            prev_ok = 1'b1;
        end
        if (rel >= 0 && rel < 256) begin
            rdy_hist[rel] = s_ready;
            vld_hist[rel] = nms_valid;
        end
        if (rel >= 1) begin
            if (nms_valid) beats.push_back('{nms_din1, nms_din2, nms_din3, row_idx, cyc});
            if (frame_done) begin
                fd_cyc.push_back(cyc);
                if (busy) fd_busy_bad++;
            end
            if (s_valid && s_ready) begin
                acc_cnt++;
                if (acc_cnt == 3 * W) t3 = cyc;
            end
        end
        b   = 2'(dut.r_centre - 11'd1);
        hit = dut.w_wr_en && dut.w_rd_en &&
              (dut.r_wr_slot == b || dut.r_wr_slot == (b + 2'd1) || dut.r_wr_slot == (b + 2'd2));
        if (hit) coll_cnt++;
        assert (!hit) else $error("FAIL rw_collision: slot %0d written while being read", dut.r_wr_slot);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic bit pick(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 3) == 0;
            2:       return $urandom_range(0, 1) == 1;
            default: return $urandom_range(0, 3) == 0;
        endcase
    endfunction

    task automatic fill_img(input bit rnd);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = rnd ? PW'($urandom) : PW'(r * 16 + c);
    endtask

    // Pulses frame_start in the current cycle and streams the image; returns early at cycle abort_rel.
    task automatic drive_frame(input int mode, input int abort_rel, output bit timeout);
        int row, col, k;
        bit acc;
        timeout = 1'b0;
        row = 0; col = 0;
        frame_start = 1'b1;
        s_data  = img[0][0];
        s_valid = pick(mode, 0);
        @(posedge clk); #1;
        frame_start = 1'b0;
        k = 1;
        while (row < H) begin
            if (abort_rel > 0 && k == abort_rel) return;
            s_data  = img[row][col];
            s_valid = pick(mode, k);
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            k++;
            if (acc) begin
                if (col == W - 1) begin col = 0; row++; end
                else col++;
            end
            if (k > BUDGET) begin timeout = 1'b1; break; end
        end
        s_valid = 1'b0;
        while (!timeout && fd_cyc.size() == 0) begin
            if (abort_rel > 0 && k == abort_rel) return;
            if (k > BUDGET) begin timeout = 1'b1; break; end
            @(posedge clk); #1;
            k++;
        end
        repeat (4) begin @(posedge clk); #1; end
    endtask

    // Reference: burst b (centre r=b+1) carries rows r-1,r,r+1 for columns 0..W-1 in order.
    task automatic check_frame(input int exp_beats, input int exp_done, input int exp_din2);
        int n, r, c;
        n = beats.size();
        check("beat_count", n, exp_beats);
        if (n > exp_beats) n = exp_beats;
        for (int i = 0; i < n; i++) begin
            r = 1 + i / W;
            c = i % W;
            check("beat_window",
                  {beats[i].ri, beats[i].d1, beats[i].d2, beats[i].d3},
                  {11'(r), img[r-1][c], img[r][c], img[r+1][c]});
            if (i > 0) begin
                if (c != 0) check("burst_contiguous", beats[i].c - beats[i-1].c, 1);
                else        check("gap_at_least_row_gap", (beats[i].c - beats[i-1].c - 1) >= GAP, 1);
            end
        end
        if (n > 0) begin
            check("first_beat_latency", beats[0].c - t3, 2);
            if (exp_din2 >= 0) check("first_din2", beats[0].d2, exp_din2);
        end
        check("frame_done_count", fd_cyc.size(), exp_done);
        if (fd_cyc.size() > 0 && n > 0)
            check("frame_done_after_last_beat", fd_cyc[0] - beats[n-1].c, 1);
        check("busy_low_at_done", fd_busy_bad, 0);
    endtask

    typedef struct {
        int mode;
        bit rnd;
        int exp_beats;
        int exp_done;
        int exp_din2;
    } vec_t;

    vec_t tbl [6];

    initial begin
        bit to;
        tbl[0] = '{0, 1'b0, (H-2)*W, 1, 16};
        tbl[1] = '{1, 1'b0, (H-2)*W, 1, 16};
        tbl[2] = '{2, 1'b0, (H-2)*W, 1, 16};
        tbl[3] = '{0, 1'b1, (H-2)*W, 1, -1};
        tbl[4] = '{2, 1'b1, (H-2)*W, 1, -1};
        tbl[5] = '{3, 1'b1, (H-2)*W, 1, -1};

        rst = 1'b1; frame_start = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {s_ready, nms_valid, nms_din1, nms_din2, nms_din3, row_idx, frame_done, busy}, 64'd0);
        rst = 1'b0;
        s_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("idle_not_ready", {s_ready, busy, nms_valid}, 3'b000);
        s_valid = 1'b0;

        // Table-driven frames with different valid patterns and data.
        for (int t = 0; t < 6; t++) begin
            fill_img(tbl[t].rnd);
            drive_frame(tbl[t].mode, 0, to);
            check("frame_timeout", to, 0);
            check_frame(tbl[t].exp_beats, tbl[t].exp_done, tbl[t].exp_din2);
        end

        // Continuous stream: exact cycle positions, including the one-cycle full-ring stall.
        fill_img(1'b0);
        drive_frame(0, 0, to);
        check("frame_timeout", to, 0);
        check_frame((H-2)*W, 1, 16);
        check("third_row_rel", t3 - fs_cyc, 24);
        if (beats.size() > 0) check("first_beat_rel", beats[0].c - fs_cyc, 26);
        if (fd_cyc.size() > 0) check("frame_done_rel", fd_cyc[0] - fs_cyc, 54);
        check("ready_before_full", rdy_hist[32], 1);
        check("ready_ring_full", rdy_hist[33], 0);
        check("ready_after_free", rdy_hist[34], 1);
        check("ready_all_rows_in", rdy_hist[42], 0);

        // Abort during burst 2, then a clean frame.
        drive_frame(0, 38, to);
        check("abort_mid_burst2", {nms_valid, row_idx}, {1'b1, 11'd2});
        check("no_done_aborted", fd_cyc.size(), 0);
        drive_frame(0, 0, to);
        check("frame_timeout", to, 0);
        check("valid_drop_after_abort", vld_hist[1], 0);
        check_frame((H-2)*W, 1, 16);

        // Asynchronous reset during burst 2.
        drive_frame(0, 38, to);
        rst = 1'b1;
        #1;
        check("async_reset_outputs",
              {s_ready, nms_valid, nms_din1, nms_din2, nms_din3, row_idx, frame_done, busy}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("ready_low_after_reset", {s_ready, nms_valid}, 2'b00);
        end
        s_valid = 1'b0;

        // Randomised frames against the reference.
        for (int f = 0; f < 4; f++) begin
            fill_img(1'b1);
            drive_frame(2 + (f % 2), 0, to);
            check("frame_timeout", to, 0);
            check_frame((H-2)*W, 1, -1);
        end

        check("no_rw_collision", coll_cnt, 0);
        check("din_hold_when_idle", hold_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
